mic_capture_ctrl: RTL and testbench
===================================

// Module: mic_capture_ctrl
// PURPOSE
// Sequences the I2S microphone front end and frames its sample stream for the vocoder.
// Holds the mic interface in reset until capture starts, then discards the mic's wake-up samples.
// Groups the remaining samples into fixed-length frames tagged with start/end flags.
// Buffers samples in a small FIFO with a valid/ready output, because the mic itself cannot be stalled.
// PARAMETERS
// SAMPLE_WIDTH  24   width of signed mic samples
// FRAME_LEN     256  samples per frame (>=2)
// WAKE_SAMPLES  1024 valid samples discarded after enable (>=1)
// FIFO_DEPTH    8    output FIFO entries (power of 2, >=2)
// PORTS
// clk_in            in   1             system clock; all logic on posedge
// rst_in            in   1             synchronous, active-high reset
// start_in          in   1             1-cycle pulse: begin capture (honoured only in IDLE)
// stop_in           in   1             1-cycle pulse: end capture at next frame boundary
// sample_in         in   SAMPLE_WIDTH  signed mic sample, clk_in domain
// sample_valid_in   in   1             1-cycle strobe qualifying sample_in
// mic_en_out        out  1             1 = mic interface running; drive mic reset with its inverse
// sample_out        out  SAMPLE_WIDTH  FIFO head sample
// frame_start_out   out  1             head sample is frame position 0
// frame_end_out     out  1             head sample is frame position FRAME_LEN-1
// valid_out         out  1             FIFO non-empty
// ready_in          in   1             downstream accepts head when valid_out && ready_in
// busy_out          out  1             state != IDLE
// overflow_out      out  1             sticky: at least one sample dropped on a full FIFO
// drop_count_out    out  16            saturating count of dropped samples
// BEHAVIOUR
// Reset: state=IDLE, FIFO empty, all counters 0; all outputs 0 (valid_out, mic_en_out, flags,
//   overflow_out, drop_count_out, sample_out). Reset mid-operation aborts at once and discards the FIFO.
// FSM (registered; mic_en_out=1 in WAKEUP and CAPTURE only):
//   IDLE:    start_in -> WAKEUP, wake_cnt=0, frame_pos=0, overflow/drop_count cleared.
//   WAKEUP:  each sample_valid_in increments wake_cnt; sample discarded; wake_cnt==WAKE_SAMPLES-1
//            with valid -> CAPTURE. stop_in -> IDLE (no frame has started).
//   CAPTURE: each sample_valid_in is written with flags from frame_pos; frame_pos wraps
//            FRAME_LEN-1 -> 0. stop_in sets stop_pend. At frame_pos==0 with stop_pend (or stop_in
//            asserted while frame_pos==0) -> DRAIN; the sample completing a frame is still written.
//   DRAIN:   sample_valid_in ignored; FIFO empty -> IDLE.
// Concurrent strobes: start_in+stop_in in IDLE -> stay IDLE (stop wins). start_in outside IDLE is ignored.
//   stop_in in IDLE/DRAIN is ignored.
// FIFO: first-word fall-through. A write in cycle N is visible on valid_out/sample_out in N+1.
//   A pop on valid_out&&ready_in advances the head in the next cycle.
//   Write while full is accepted only if a pop happens in the same cycle.
//   Otherwise the sample is dropped: overflow_out=1, drop_count_out+1 (saturates at 16'hFFFF).
//   frame_pos still advances on a dropped sample, so frames stay time-aligned, and a frame delivered
//   downstream may be short. sample_out and flags are held while valid_out && !ready_in.
// Width: samples are stored and passed unmodified; there is no scaling or sign extension.
// TESTING (bench params FRAME_LEN=4, WAKE_SAMPLES=3, FIFO_DEPTH=4)
// 1 start, 3 valids (discarded), then 8 valids 1..8, ready_in=1 -> outputs 1..8; frame_start on 1,5;
//   frame_end on 4,8; mic_en_out=1 from cycle after start.
// 2 stop_in after sample 6 of capture -> samples 7,8 still written, 9+ ignored, DRAIN,
//   IDLE once FIFO empty; mic_en_out=0 on DRAIN entry.
// 3 ready_in=0, 6 valids in CAPTURE -> 4 stored, overflow_out=1, drop_count_out=2;
//   ready_in=1 then 8th... -> outputs first 4 in order.
// 4 FIFO full, valid_out&&ready_in in same cycle as sample_valid_in -> no drop, count stays 4.
// 5 rst_in mid-CAPTURE with 3 in FIFO -> next cycle valid_out=0, mic_en_out=0, busy_out=0,
//   drop_count_out=0.
// 6 stop_in during WAKEUP after 1 valid -> IDLE, no output; start_in+stop_in same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/mic_capture_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mic_capture_ctrl_if                                             |
// | Brief    : Framed sample stream from the mic capture block (valid/ready).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mic_capture_ctrl_if #(
  parameter int SAMPLE_WIDTH = 24
) ();
  logic [SAMPLE_WIDTH-1:0] sample_out;
  logic                    frame_start_out;
  logic                    frame_end_out;
  logic                    valid_out;
  logic                    ready_in;

  modport master (
    output sample_out,
    output frame_start_out,
    output frame_end_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  sample_out,
    input  frame_start_out,
    input  frame_end_out,
    input  valid_out,
    output ready_in
  );
endinterface
`default_nettype wire

// File: rtl/mic_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mic_capture_ctrl                                                |
// | Brief    : I2S mic sequencing, wake-up discard, framing and output FIFO.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mic_capture_ctrl #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FRAME_LEN    = 256,
  parameter int WAKE_SAMPLES = 1024,
  parameter int FIFO_DEPTH   = 8
) (
  input  wire logic                    clk_in,
  input  wire logic                    rst_in,
  input  wire logic                    start_in,
  input  wire logic                    stop_in,
  input  wire logic [SAMPLE_WIDTH-1:0] sample_in,
  input  wire logic                    sample_valid_in,
  output logic                         mic_en_out,
  output logic                         busy_out,
  output logic                         overflow_out,
  output logic [15:0]                  drop_count_out,
  mic_capture_ctrl_if.master           out_if
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_pos_w  = $clog2(FRAME_LEN);
  localparam int c_wake_w = (WAKE_SAMPLES > 1) ? $clog2(WAKE_SAMPLES) : 1;
  localparam int c_ent_w  = SAMPLE_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAKEUP  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_wake_w-1:0] r_wake_cnt;
  logic [c_pos_w-1:0]  r_frame_pos;
  logic                r_stop_pend;
  logic                r_overflow;
  logic [15:0]         r_drop_count;
  logic [c_ent_w-1:0]  r_mem [FIFO_DEPTH];
  logic [c_ptr_w:0]    r_wr_ptr;
  logic [c_ptr_w:0]    r_rd_ptr;

  logic               w_arm;
  logic               w_wake_inc;
  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_empty;
  logic               w_full;
  logic               w_pos_zero;
  logic               w_pos_last;
  logic               w_wake_last;
  logic [c_ptr_w:0]   w_count;
  logic [c_ent_w-1:0] w_head;

  assign w_pos_zero  = (r_frame_pos == '0);
  assign w_pos_last  = (r_frame_pos == c_pos_w'(FRAME_LEN - 1));
  assign w_wake_last = (r_wake_cnt == c_wake_w'(WAKE_SAMPLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_wake_inc  = 1'b0;
    w_push_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in && !stop_in) begin
          w_state_nxt = S_WAKEUP;
          w_arm       = 1'b1;
        end
      end
      S_WAKEUP: begin
        if (stop_in) begin
          w_state_nxt = S_IDLE;
        end else if (sample_valid_in) begin
          if (w_wake_last) w_state_nxt = S_CAPTURE;
          else             w_wake_inc  = 1'b1;
        end
      end
      S_CAPTURE: begin
        // Leaving only on a frame boundary keeps every delivered frame whole in time.
        if (w_pos_zero && (r_stop_pend || stop_in)) w_state_nxt = S_DRAIN;
        else if (sample_valid_in)                   w_push_req  = 1'b1;
      end
      S_DRAIN: begin
        if (w_empty) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wake_cnt   <= '0;
      r_frame_pos  <= '0;
      r_stop_pend  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_arm) begin
      r_wake_cnt   <= '0;
      r_frame_pos  <= '0;
      r_stop_pend  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_wake_inc) r_wake_cnt <= r_wake_cnt + 1'b1;
      // Position advances even for dropped samples so frames stay time-aligned.
      if (w_push_req) r_frame_pos <= w_pos_last ? '0 : r_frame_pos + 1'b1;
      if ((r_state == S_CAPTURE) && stop_in) r_stop_pend <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == (c_ptr_w + 1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && out_if.ready_in;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {w_pos_last, w_pos_zero, sample_in};
  end

  assign w_head = r_mem[r_rd_ptr[c_ptr_w-1:0]];

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign out_if.valid_out       = !w_empty;
  assign out_if.sample_out      = w_empty ? '0   : w_head[SAMPLE_WIDTH-1:0];
  assign out_if.frame_start_out = w_empty ? 1'b0 : w_head[SAMPLE_WIDTH];
  assign out_if.frame_end_out   = w_empty ? 1'b0 : w_head[SAMPLE_WIDTH+1];

  assign mic_en_out     = (r_state == S_WAKEUP) || (r_state == S_CAPTURE);
  assign busy_out       = (r_state != S_IDLE);
  assign overflow_out   = r_overflow;
  assign drop_count_out = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_mic_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mic_capture_ctrl                                             |
// | Brief    : Directed self-checking bench for mic_capture_ctrl.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mic_capture_ctrl;
  localparam int SW = 24;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          stop_in;
  logic [SW-1:0] sample_in;
  logic          sample_valid_in;
  logic          mic_en_out;
  logic          busy_out;
  logic          overflow_out;
  logic [15:0]   drop_count_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  mic_capture_ctrl_if #(.SAMPLE_WIDTH(SW)) out_if ();

  mic_capture_ctrl #(
    .SAMPLE_WIDTH (SW),
    .FRAME_LEN    (4),
    .WAKE_SAMPLES (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .stop_in         (stop_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .mic_en_out      (mic_en_out),
    .busy_out        (busy_out),
    .overflow_out    (overflow_out),
    .drop_count_out  (drop_count_out),
    .out_if          (out_if)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input int v);
    sample_in       = SW'(v);
    sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic v, input int s,
                             input logic fs, input logic fe);
    check({tag, "_valid"}, 32'(out_if.valid_out), 32'(v));
    if (v) begin
      check({tag, "_sample"}, 32'(out_if.sample_out), 32'(s));
      check({tag, "_fstart"}, 32'(out_if.frame_start_out), 32'(fs));
      check({tag, "_fend"}, 32'(out_if.frame_end_out), 32'(fe));
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic start_and_wake();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) push(900 + i);
  endtask

  initial begin
    rst_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    sample_in = '0; sample_valid_in = 1'b0; out_if.ready_in = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_if.valid_out), 32'd0);
    check("rst_sample", 32'(out_if.sample_out), 32'd0);
    check("rst_flags", 32'({out_if.frame_start_out, out_if.frame_end_out}), 32'd0);
    check("rst_mic_en", 32'(mic_en_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_drops", 32'(drop_count_out), 32'd0);

    // 1: wake-up discard, then two full frames streamed through
    out_if.ready_in = 1'b1;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("t1_mic_en", 32'(mic_en_out), 32'd1);
    check("t1_busy", 32'(busy_out), 32'd1);
    for (int i = 0; i < 3; i++) push(900 + i);
    tick();
    check("t1_wake_discard", 32'(out_if.valid_out), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      push(k);
      expect_head($sformatf("t1_s%0d", k), 1'b1, k, (k == 1 || k == 5), (k % 4 == 0));
    end
    tick();
    check("t1_empty", 32'(out_if.valid_out), 32'd0);

    // 2: stop mid-frame completes the frame, then drains
    do_reset();
    out_if.ready_in = 1'b1;
    start_and_wake();
    for (int k = 1; k <= 6; k++) push(k);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    out_if.ready_in = 1'b0;
    push(7);
    push(8);
    push(9);
    check("t2_drain_mic_en", 32'(mic_en_out), 32'd0);
    check("t2_drain_busy", 32'(busy_out), 32'd1);
    expect_head("t2_h7", 1'b1, 7, 1'b0, 1'b0);
    out_if.ready_in = 1'b1;
    push(10);
    expect_head("t2_h8", 1'b1, 8, 1'b0, 1'b1);
    tick();
    expect_head("t2_h_empty", 1'b0, 0, 1'b0, 1'b0);
    check("t2_busy_before_idle", 32'(busy_out), 32'd1);
    tick();
    check("t2_idle", 32'(busy_out), 32'd0);

    // 3: overflow with downstream stalled
    do_reset();
    out_if.ready_in = 1'b0;
    start_and_wake();
    for (int k = 21; k <= 26; k++) push(k);
    check("t3_ovf", 32'(overflow_out), 32'd1);
    check("t3_drops", 32'(drop_count_out), 32'd2);
    tick();
    expect_head("t3_hold", 1'b1, 21, 1'b1, 1'b0);
    out_if.ready_in = 1'b1;
    tick();
    expect_head("t3_h22", 1'b1, 22, 1'b0, 1'b0);
    tick();
    expect_head("t3_h23", 1'b1, 23, 1'b0, 1'b0);
    tick();
    expect_head("t3_h24", 1'b1, 24, 1'b0, 1'b1);
    tick();
    expect_head("t3_empty", 1'b0, 0, 1'b0, 1'b0);

    // 4: write into a full FIFO with a simultaneous pop is not dropped
    out_if.ready_in = 1'b0;
    for (int k = 31; k <= 34; k++) push(k);
    out_if.ready_in = 1'b1;
    push(35);
    check("t4_drops", 32'(drop_count_out), 32'd2);
    expect_head("t4_h32", 1'b1, 32, 1'b0, 1'b1);
    tick();
    expect_head("t4_h33", 1'b1, 33, 1'b1, 1'b0);
    tick();
    expect_head("t4_h34", 1'b1, 34, 1'b0, 1'b0);
    tick();
    expect_head("t4_h35", 1'b1, 35, 1'b0, 1'b0);
    tick();
    expect_head("t4_empty", 1'b0, 0, 1'b0, 1'b0);

    // 5: reset mid-capture discards everything
    out_if.ready_in = 1'b0;
    push(41);
    push(42);
    push(43);
    expect_head("t5_pre", 1'b1, 41, 1'b0, 1'b1);
    check("t5_pre_drops", 32'(drop_count_out), 32'd2);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("t5_valid", 32'(out_if.valid_out), 32'd0);
    check("t5_mic_en", 32'(mic_en_out), 32'd0);
    check("t5_busy", 32'(busy_out), 32'd0);
    check("t5_drops", 32'(drop_count_out), 32'd0);
    check("t5_ovf", 32'(overflow_out), 32'd0);

    // 6: stop during wake-up, and start+stop together in IDLE
    out_if.ready_in = 1'b1;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    push(51);
    check("t6_wake_busy", 32'(busy_out), 32'd1);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("t6_stop_busy", 32'(busy_out), 32'd0);
    check("t6_stop_mic_en", 32'(mic_en_out), 32'd0);
    for (int k = 0; k < 4; k++) push(60 + k);
    check("t6_no_output", 32'(out_if.valid_out), 32'd0);
    start_in = 1'b1;
    stop_in  = 1'b1;
    tick();
    start_in = 1'b0;
    stop_in  = 1'b0;
    check("t6_start_stop_idle", 32'(busy_out), 32'd0);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("t6_restart", 32'(busy_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
